inst_mem_loader: RTL and testbench



---
 rtl/inst_mem_loader.sv | 166 ++++++++++++++++
 tb/tb_inst_mem_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: boot-time instruction memory writer.
// Takes a length-prefixed little-endian byte stream, packs 32-bit words and
// writes them at consecutive word addresses from 0 while holding the core.
module inst_mem_loader #(
    parameter int unsigned CPU_WIDTH           = 32,
    parameter int unsigned INST_MEM_ADDR_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           byte_vld,
    input  logic [7:0]                     byte_data,
    output logic                           byte_rdy,
    output logic                           mem_we,
    output logic [INST_MEM_ADDR_WIDTH-1:0] mem_waddr,
    output logic [CPU_WIDTH-1:0]           mem_wdata,
    output logic                           cpu_hold,
    output logic                           load_done,
    output logic                           load_err,
    output logic [INST_MEM_ADDR_WIDTH:0]   word_cnt
);

    localparam int unsigned AW = INST_MEM_ADDR_WIDTH;
    localparam logic [32:0] Depth   = 33'd1 << AW;
    localparam logic [AW:0] CntOne  = 1;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StDone,
        StErr
    } state_e;

    state_e                 state_q,     state_d;
    logic [1:0]             idx_q,       idx_d;
    logic [31:0]            len_q,       len_d;
    logic [CPU_WIDTH-1:0]   asm_q,       asm_d;
    logic [AW:0]            word_cnt_q,  word_cnt_d;
    logic                   mem_we_q,    mem_we_d;
    logic [AW-1:0]          mem_waddr_q, mem_waddr_d;
    logic [CPU_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   byte_rdy_q,  byte_rdy_d;
    logic                   cpu_hold_q,  cpu_hold_d;
    logic                   load_done_q, load_done_d;
    logic                   load_err_q,  load_err_d;

    logic                   xfer;
    logic [31:0]            len_next;
    logic [CPU_WIDTH-1:0]   asm_next;
    logic                   last_word;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        asm_d       = asm_q;
        word_cnt_d  = word_cnt_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        load_err_d  = load_err_q;

        xfer      = byte_vld && byte_rdy_q;
        // New bytes enter at the top so the first byte ends up in bits 7:0.
        len_next  = {byte_data, len_q[31:8]};
        asm_next  = {byte_data, asm_q[CPU_WIDTH-1:8]};
        last_word = ({22'd0, word_cnt_q} + 33'd1) == {1'b0, len_q};

        // The counter advances on the edge that commits the write.
        if (mem_we_q) begin
            word_cnt_d = word_cnt_q + CntOne;
        end

        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StLen;
                    idx_d      = 2'd0;
                    len_d      = 32'd0;
                    word_cnt_d = '0;
                    load_err_d = 1'b0;
                end
            end
            StLen: begin
                if (xfer) begin
                    len_d = len_next;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (len_next == 32'd0) begin
                            state_d = StDone;
                        end else if ({1'b0, len_next} > Depth) begin
                            state_d = StErr;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    asm_d = asm_next;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = word_cnt_q[AW-1:0];
                        mem_wdata_d = asm_next;
                        if (last_word) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        byte_rdy_d  = (state_d == StLen) || (state_d == StData);
        cpu_hold_d  = byte_rdy_d;
        load_done_d = (state_d == StDone);
        if (state_d == StErr) begin
            load_err_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= 2'd0;
            len_q       <= 32'd0;
            asm_q       <= '0;
            word_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            byte_rdy_q  <= 1'b0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            asm_q       <= asm_d;
            word_cnt_q  <= word_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            byte_rdy_q  <= byte_rdy_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign byte_rdy  = byte_rdy_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: random byte streams against a word-level model.
module tb_inst_mem_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, start, byte_vld;
    logic [7:0]    byte_data;
    logic          byte_rdy, mem_we, cpu_hold, load_done, load_err;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [AW+31:0] obs[$];   // observed writes {addr, data}
    logic [7:0]     stim[$];  // header + payload bytes of the current load

    inst_mem_loader #(.CPU_WIDTH(32), .INST_MEM_ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .byte_vld  (byte_vld),
        .byte_data (byte_data),
        .byte_rdy  (byte_rdy),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    // Write monitor.
    always @(negedge clk) begin
        if (mem_we === 1'b1) obs.push_back({mem_waddr, mem_wdata});
    end

    // Model: word i is payload bytes 4i..4i+3, little-endian, after the 4-byte header.
    function automatic logic [31:0] model_word(input int i);
        return {stim[4*i+7], stim[4*i+6], stim[4*i+5], stim[4*i+4]};
    endfunction

    task automatic build_stim(input int unsigned len, input int nwords);
        stim.delete();
        for (int k = 0; k < 4; k++) stim.push_back(8'((len >> (8 * k)) & 32'hFF));
        for (int k = 0; k < 4 * nwords; k++) stim.push_back(8'($urandom));
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int n;
        repeat (gap) @(negedge clk);
        byte_vld  = 1'b1;
        byte_data = b;
        n = 0;
        while (byte_rdy !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_byte_timeout: byte_rdy=%b after %0d cycles, want 1", byte_rdy, n);
        end else begin
            @(negedge clk);
        end
        byte_vld  = 1'b0;
        byte_data = 8'($urandom);
    endtask

    task automatic stream(input int from, input int to, input int unsigned gapmax);
        for (int i = from; i < to; i++) send_byte(stim[i], $urandom_range(gapmax, 0));
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({byte_rdy, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err, word_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b we=%b addr=%0d data=%h hold=%b done=%b err=%b cnt=%0d want all 0",
                     byte_rdy, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err, word_cnt);
        end
        rst = 1'b0;
        byte_vld = 1'b1;
        repeat (3) @(negedge clk);
        byte_vld = 1'b0;
        n_cmp++;
        if (byte_rdy !== 1'b0 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_rdy: got rdy=%b hold=%b want 0 0", byte_rdy, cpu_hold);
        end
    endtask

    task automatic test_basic;
        logic [31:0] exp_w[3];
        exp_w = '{32'h0000_0013, 32'h0010_0093, 32'h0000_006F};
        obs.delete();
        stim = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        pulse_start();
        n_cmp++;
        if (byte_rdy !== 1'b1 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_len_state: got rdy=%b hold=%b want 1 1", byte_rdy, cpu_hold);
        end
        stream(0, 16, 0);
        n_cmp++;
        if ({mem_we, mem_waddr, load_done, cpu_hold, byte_rdy} !== {1'b1, AW'(2), 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_last_cycle: got we=%b addr=%0d done=%b hold=%b rdy=%b want 1 2 1 0 0",
                     mem_we, mem_waddr, load_done, cpu_hold, byte_rdy);
        end
        @(negedge clk);
        n_cmp++;
        if (word_cnt !== 11'd3 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_cnt: got cnt=%0d err=%b want 3 0", word_cnt, load_err);
        end
        n_cmp++;
        if (obs.size() != 3) begin
            n_fail++;
            $display("FAIL basic_nwrites: got %0d want 3", obs.size());
        end
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== {AW'(i), exp_w[i]}) begin
                n_fail++;
                $display("FAIL basic_write%0d: got %h want %h", i, obs[i], {AW'(i), exp_w[i]});
            end
        end
    endtask

    task automatic test_len_zero;
        obs.delete();
        build_stim(0, 0);
        pulse_start();
        stream(0, 4, 1);
        n_cmp++;
        if ({load_done, byte_rdy, load_err, cpu_hold} !== 4'b1000) begin
            n_fail++;
            $display("FAIL len0_state: got done=%b rdy=%b err=%b hold=%b want 1 0 0 0",
                     load_done, byte_rdy, load_err, cpu_hold);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (obs.size() != 0 || word_cnt !== '0) begin
            n_fail++;
            $display("FAIL len0_nowrite: got writes=%0d cnt=%0d want 0 0", obs.size(), word_cnt);
        end
    endtask

    task automatic test_len_err;
        obs.delete();
        build_stim(DEPTH + 1, 0);
        pulse_start();
        stream(0, 4, 2);
        n_cmp++;
        if ({load_err, byte_rdy, load_done, cpu_hold} !== 4'b1000) begin
            n_fail++;
            $display("FAIL err_state: got err=%b rdy=%b done=%b hold=%b want 1 0 0 0",
                     load_err, byte_rdy, load_done, cpu_hold);
        end
        byte_vld = 1'b1;
        repeat (6) @(negedge clk);
        byte_vld = 1'b0;
        n_cmp++;
        if (obs.size() != 0 || load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got writes=%0d err=%b want 0 1", obs.size(), load_err);
        end
        pulse_start();
        n_cmp++;
        if (load_err !== 1'b0 || byte_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_restart: got err=%b rdy=%b want 0 1", load_err, byte_rdy);
        end
        build_stim(1, 1);
        stream(0, 8, 2);
        @(negedge clk);
        n_cmp++;
        if (obs.size() != 1 || load_done !== 1'b1 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_recover: got writes=%0d done=%b err=%b want 1 1 0",
                     obs.size(), load_done, load_err);
        end else begin
            n_cmp++;
            if (obs[0] !== {AW'(0), model_word(0)}) begin
                n_fail++;
                $display("FAIL err_recover_word: got %h want %h", obs[0], {AW'(0), model_word(0)});
            end
        end
    endtask

    task automatic test_gaps;
        obs.delete();
        build_stim(2, 2);
        pulse_start();
        stream(0, 12, 5);
        n_cmp++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_done: got done=%b hold=%b want 1 0", load_done, cpu_hold);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs.size() != 2 || word_cnt !== 11'd2) begin
            n_fail++;
            $display("FAIL gaps_nwrites: got %0d cnt=%0d want 2 2", obs.size(), word_cnt);
        end
        for (int i = 0; i < 2 && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== {AW'(i), model_word(i)}) begin
                n_fail++;
                $display("FAIL gaps_write%0d: got %h want %h", i, obs[i], {AW'(i), model_word(i)});
            end
        end
    endtask

    task automatic test_rst_mid;
        obs.delete();
        build_stim(4, 4);
        pulse_start();
        stream(0, 10, 1);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({byte_rdy, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err, word_cnt} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_values: got rdy=%b we=%b addr=%0d data=%h hold=%b done=%b err=%b cnt=%0d want all 0",
                     byte_rdy, mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err, word_cnt);
        end
        rst = 1'b0;
        byte_vld = 1'b1;
        repeat (8) begin
            byte_data = 8'($urandom);
            @(negedge clk);
        end
        byte_vld = 1'b0;
        n_cmp++;
        if (obs.size() != 1) begin
            n_fail++;
            $display("FAIL rstmid_nwrites: got %0d want 1", obs.size());
        end else begin
            n_cmp++;
            if (obs[0] !== {AW'(0), model_word(0)}) begin
                n_fail++;
                $display("FAIL rstmid_word0: got %h want %h", obs[0], {AW'(0), model_word(0)});
            end
        end
    endtask

    task automatic test_start_in_data;
        obs.delete();
        build_stim(3, 3);
        pulse_start();
        stream(0, 6, 0);
        pulse_start();
        stream(6, 16, 1);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs.size() != 3 || word_cnt !== 11'd3 || load_done !== 1'b1) begin
            n_fail++;
            $display("FAIL startdata_end: got writes=%0d cnt=%0d done=%b want 3 3 1",
                     obs.size(), word_cnt, load_done);
        end
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== {AW'(i), model_word(i)}) begin
                n_fail++;
                $display("FAIL startdata_write%0d: got %h want %h", i, obs[i], {AW'(i), model_word(i)});
            end
        end
    endtask

    task automatic test_random_loads;
        int unsigned len;
        int unsigned gap;
        int          bad;
        for (int r = 0; r < 7; r++) begin
            len = (r == 6) ? DEPTH : $urandom_range(8, 1);
            gap = (r == 6) ? 0 : $urandom_range(3, 0);
            obs.delete();
            build_stim(len, int'(len));
            pulse_start();
            stream(0, 4 + 4 * int'(len), gap);
            repeat (2) @(negedge clk);
            n_cmp++;
            if (obs.size() != len || word_cnt !== (AW+1)'(len) || load_done !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d_end: got writes=%0d cnt=%0d done=%b want %0d %0d 1",
                         r, obs.size(), word_cnt, load_done, len, len);
            end
            bad = 0;
            for (int i = 0; i < int'(len) && i < obs.size(); i++) begin
                n_cmp++;
                if (obs[i] !== {AW'(i), model_word(i)}) begin
                    n_fail++;
                    if (bad < 4) $display("FAIL rand%0d_write%0d: got %h want %h",
                                          r, i, obs[i], {AW'(i), model_word(i)});
                    bad++;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        byte_vld  = 1'b0;
        byte_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic();
        test_len_zero();
        test_len_err();
        test_gaps();
        test_rst_mid();
        test_start_in_data();
        test_random_loads();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
